lcd_bus_arbiter: RTL and testbench

Parametrised N-channel arbiter for the shared HD44780-style LCD bus (RS, RW, E, DATA). It replaces the fixed two-source init/button select with registered, request/grant-based ownership of the bus. It adds round-robin fairness, an init lock reserving channel 0, and an idle guard interval between owners so E never glitches across a handover. It sits between the LCD client controllers (init sequencer, button writer, text writers) and the LCD pins.

---
 rtl/lcd_pkg.sv | 27 ++
 rtl/lcd_rr_pick.sv | 38 +++
 rtl/lcd_bus_arbiter.sv | 127 ++++++++++++
 tb/tb_lcd_bus_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_pkg
// Purpose  : Shared constants, arbiter state encoding and width helper for
//            the LCD bus arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
package lcd_pkg;

  // Default idle interval (cycles with E low) between two bus owners.
  localparam int c_guard_cyc_default = 4;

  // Width of the guard counter; covers the full 0..255 guard range.
  localparam int c_guard_cnt_w = 8;

  // Arbiter state encoding.
  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_grant = 2'd1;
  localparam logic [1:0] c_st_guard = 2'd2;

  // Owner index width: $clog2 of the channel count, never narrower than 1.
  function automatic int ch_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : lcd_rr_pick
// Purpose  : Combinational round-robin picker. Scans eligible channels
//            starting one past ptr and returns the first hit.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_rr_pick #(
  parameter int N_CH = 2,
  parameter int CH_W = 1
) (
  input  logic [N_CH-1:0] eligible,
  input  logic [CH_W-1:0] ptr,
  output logic [N_CH-1:0] onehot,
  output logic [CH_W-1:0] idx,
  output logic            valid
);

  logic [CH_W-1:0] w_k;

  // Walk the channels in rotated order; the first eligible one wins.
  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    w_k    = '0;
    for (int off = 1; off <= N_CH; off++) begin
      w_k = CH_W'((int'(ptr) + off) % N_CH);
      if (!valid && eligible[w_k]) begin
        onehot[w_k] = 1'b1;
        idx         = w_k;
        valid       = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/lcd_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lcd_bus_arbiter
// Purpose  : Request/grant arbiter for the shared HD44780-style LCD bus with
//            round-robin fairness, channel-0 init lock and a guard interval
//            (E held low) between successive owners.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int DATA_W    = 8,
  parameter int GUARD_CYC = c_guard_cyc_default,
  localparam int CH_W     = ch_width(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   init_lock,
  input  logic [N_CH-1:0]        req,
  input  logic [N_CH-1:0]        rs_in,
  input  logic [N_CH-1:0]        rw_in,
  input  logic [N_CH-1:0]        e_in,
  input  logic [N_CH*DATA_W-1:0] data_in,
  output logic [N_CH-1:0]        grant,
  output logic [CH_W-1:0]        owner,
  output logic                   busy,
  output logic                   lcd_rs,
  output logic                   lcd_rw,
  output logic                   lcd_e,
  output logic [DATA_W-1:0]      lcd_data
);

  logic [1:0]               r_state;
  logic [N_CH-1:0]          r_grant;
  // The last owner doubles as the round-robin pointer.
  logic [CH_W-1:0]          r_owner;
  logic [c_guard_cnt_w-1:0] r_cnt;
  logic                     r_lcd_rs;
  logic                     r_lcd_rw;
  logic                     r_lcd_e;
  logic [DATA_W-1:0]        r_lcd_data;

  logic [N_CH-1:0]          w_eligible;
  logic [N_CH-1:0]          w_onehot;
  logic [CH_W-1:0]          w_idx;
  logic                     w_valid;
  logic [DATA_W-1:0]        w_data_ch [N_CH];

  // Split the flat client data bus into per-channel words.
  for (genvar k = 0; k < N_CH; k++) begin : g_unpack
    assign w_data_ch[k] = data_in[k*DATA_W +: DATA_W];
  end

  // While the init sequencer holds the lock only channel 0 may win.
  assign w_eligible = init_lock ? {{(N_CH-1){1'b0}}, req[0]} : req;

  lcd_rr_pick #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_pick (
    .eligible (w_eligible),
    .ptr      (r_owner),
    .onehot   (w_onehot),
    .idx      (w_idx),
    .valid    (w_valid)
  );

  // Arbitration state machine and registered LCD pin mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_st_idle;
      r_grant    <= '0;
      r_owner    <= '0;
      r_cnt      <= '0;
      r_lcd_rs   <= 1'b0;
      r_lcd_rw   <= 1'b0;
      r_lcd_e    <= 1'b0;
      r_lcd_data <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_valid) begin
            r_grant <= w_onehot;
            r_owner <= w_idx;
            r_state <= c_st_grant;
          end
        end
        c_st_grant: begin
          if (!req[r_owner]) begin
            // E is forced low on release even if the client left it high.
            r_grant <= '0;
            r_lcd_e <= 1'b0;
            r_cnt   <= c_guard_cnt_w'(GUARD_CYC);
            r_state <= (GUARD_CYC == 0) ? c_st_idle : c_st_guard;
          end else begin
            r_lcd_rs   <= rs_in[r_owner];
            r_lcd_rw   <= rw_in[r_owner];
            r_lcd_e    <= e_in[r_owner];
            r_lcd_data <= w_data_ch[r_owner];
          end
        end
        c_st_guard: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == c_guard_cnt_w'(1)) begin
            r_state <= c_st_idle;
          end
        end
        default: begin
          r_state <= c_st_idle;
          r_grant <= '0;
          r_lcd_e <= 1'b0;
        end
      endcase
    end
  end

  assign grant    = r_grant;
  assign owner    = r_owner;
  assign busy     = (r_state != c_st_idle);
  assign lcd_rs   = r_lcd_rs;
  assign lcd_rw   = r_lcd_rw;
  assign lcd_e    = r_lcd_e;
  assign lcd_data = r_lcd_data;

endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_bus_arbiter
// Purpose  : Self-checking bench for lcd_bus_arbiter (4 channels, 8-bit data,
//            guard of 4) with directed scenarios and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_bus_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int G = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           init_lock;
  logic [N-1:0]   req, rs_in, rw_in, e_in;
  logic [N*W-1:0] data_in;
  logic [N-1:0]   grant;
  logic [1:0]     owner;
  logic           busy, lcd_rs, lcd_rw, lcd_e;
  logic [W-1:0]   lcd_data;

  lcd_bus_arbiter #(.N_CH(N), .DATA_W(W), .GUARD_CYC(G)) dut (
    .clk(clk), .rst_n(rst_n), .init_lock(init_lock), .req(req),
    .rs_in(rs_in), .rw_in(rw_in), .e_in(e_in), .data_in(data_in),
    .grant(grant), .owner(owner), .busy(busy), .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit           m_owned;      // someone currently holds the bus
  int           m_owner;      // current or most recent owner
  int           m_guard_left; // idle cycles still to wait after a release
  logic [N-1:0] m_grant;
  logic         m_rs, m_rw, m_e;
  logic [W-1:0] m_data;

  task automatic model_reset();
    m_owned = 0; m_owner = 0; m_guard_left = 0; m_grant = '0;
    m_rs = 0; m_rw = 0; m_e = 0; m_data = '0;
  endtask

  task automatic model_update(input logic [N-1:0] s_req, input logic s_lock,
                              input logic [N-1:0] s_rs, input logic [N-1:0] s_rw,
                              input logic [N-1:0] s_e, input logic [N*W-1:0] s_data);
    logic [N-1:0] elig;
    if (m_owned) begin
      if (!s_req[m_owner]) begin
        m_owned = 0; m_grant = '0; m_e = 0; m_guard_left = G;
      end else begin
        m_rs = s_rs[m_owner]; m_rw = s_rw[m_owner]; m_e = s_e[m_owner];
        m_data = s_data[m_owner*W +: W];
      end
    end else if (m_guard_left > 0) begin
      m_guard_left--;
    end else begin
      elig = s_lock ? (s_req & 4'b0001) : s_req;
      for (int off = 1; off <= N; off++) begin
        int k;
        k = (m_owner + off) % N;
        if (!m_owned && elig[k]) begin
          m_owned = 1; m_owner = k; m_grant = '0; m_grant[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("grant",    32'(grant),    32'(m_grant));
    chk("owner",    32'(owner),    32'(m_owner));
    chk("busy",     32'(busy),     32'(m_owned || (m_guard_left > 0)));
    chk("lcd_rs",   32'(lcd_rs),   32'(m_rs));
    chk("lcd_rw",   32'(lcd_rw),   32'(m_rw));
    chk("lcd_e",    32'(lcd_e),    32'(m_e));
    chk("lcd_data", 32'(lcd_data), 32'(m_data));
  endtask

  // One clock: snapshot inputs, clock the DUT, advance model, compare.
  task automatic step();
    logic [N-1:0] s_req, s_rs, s_rw, s_e;
    logic [N*W-1:0] s_data;
    logic s_lock;
    s_req = req; s_lock = init_lock; s_rs = rs_in; s_rw = rw_in;
    s_e = e_in; s_data = data_in;
    @(posedge clk); #1;
    model_update(s_req, s_lock, s_rs, s_rw, s_e, s_data);
    compare_all();
  endtask

  task automatic wait_grant(input string name);
    for (int i = 0; i < 40 && grant == '0; i++) step();
    chk({name, "_timeout"}, 32'(grant != '0), 32'd1);
  endtask

  logic [N-1:0] rr_exp [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  int           rr_idx [4] = '{1, 2, 3, 0};
  int           hold [N];

  initial begin
    rst_n = 0; init_lock = 1; req = 4'b0011;
    rs_in = '0; rw_in = '0; e_in = '0; data_in = '0;
    model_reset();

    // Reset holds everything quiet even with requests pending.
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_e",     32'(lcd_e), 32'd0);
      chk("rst_busy",  32'(busy),  32'd0);
      chk("rst_owner", 32'(owner), 32'd0);
    end
    rst_n = 1;
    step();
    chk("lock_first_grant", 32'(grant), 32'b0001);

    // Init lock blocks other channels.
    req = 4'b0000; step();
    req = 4'b0010;
    repeat (20) begin
      step();
      chk("lock_blocks", 32'(grant), 32'd0);
    end
    init_lock = 0; step();
    chk("unlock_grant", 32'(grant), 32'b0010);

    // Passthrough on channel 2, non-owner channel 1 toggles E.
    req = 4'b0000; step();
    req = 4'b0100;
    wait_grant("pt");
    chk("pt_grant", 32'(grant), 32'b0100);
    rs_in = 4'b0100; data_in = '0; data_in[2*W +: W] = 8'hA5; e_in = 4'b0010;
    #1;
    chk("pt_rs_lag", 32'(lcd_rs), 32'd0);
    step();
    chk("pt_rs",   32'(lcd_rs),   32'd1);
    chk("pt_data", 32'(lcd_data), 32'hA5);
    chk("pt_e_nonowner", 32'(lcd_e), 32'd0);
    e_in = 4'b0110;
    repeat (3) begin
      step();
      chk("pt_e_high", 32'(lcd_e), 32'd1);
    end
    e_in = 4'b0010; step();
    chk("pt_e_low", 32'(lcd_e), 32'd0);

    // Release while E is high: E drops, data holds through guard.
    e_in = 4'b0110; step();
    chk("rel_e_pre", 32'(lcd_e), 32'd1);
    req = 4'b0000; step();
    chk("rel_e",     32'(lcd_e),   32'd0);
    chk("rel_grant", 32'(grant),   32'd0);
    data_in[2*W +: W] = 8'h5A;
    repeat (4) begin
      step();
      chk("rel_data_hold", 32'(lcd_data), 32'hA5);
    end
    e_in = '0; rs_in = '0; data_in = '0;

    // Asynchronous reset in the middle of a transfer with E high.
    req = 4'b1000; e_in = 4'b1000;
    wait_grant("ar");
    step();
    chk("ar_e_pre", 32'(lcd_e), 32'd1);
    #2 rst_n = 0;
    #1;
    chk("ar_e",     32'(lcd_e), 32'd0);
    chk("ar_grant", 32'(grant), 32'd0);
    chk("ar_busy",  32'(busy),  32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1; req = '0; e_in = '0;
    step();
    chk("ar_idle", 32'(busy), 32'd0);

    // Round-robin with everyone requesting, 3-cycle transfers.
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      int g;
      wait_grant("rr");
      chk("rr_order", 32'(grant), 32'(rr_exp[i]));
      step(); step();
      req[rr_idx[i]] = 1'b0;
      step();
      req = 4'b1111;
      g = (busy && grant == '0) ? 1 : 0;
      for (int j = 0; j < 20 && grant == '0; j++) begin
        step();
        if (busy && grant == '0) g++;
      end
      chk("rr_guard_len", 32'(g), 32'd4);
    end

    // Randomized traffic against the model.
    req = '0;
    for (int k = 0; k < N; k++) hold[k] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (req[k]) begin
          if (m_grant[k]) begin
            if (hold[k] == 0) req[k] = 1'b0;
            else hold[k]--;
          end
        end else if ($urandom_range(3) == 0) begin
          req[k] = 1'b1;
          hold[k] = $urandom_range(6, 1);
        end
      end
      if ($urandom_range(199) == 0) init_lock = ~init_lock;
      rs_in = N'($urandom); rw_in = N'($urandom); e_in = N'($urandom);
      data_in = (N*W)'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
